miter_vector_driver: RTL and testbench
======================================

Name: miter_vector_driver

Overview:
- Drives the primary inputs of a combinational-or-pipelined gold/gate miter pair and consumes both sets of primary outputs.
- Issues exhaustive or pseudo-random input vectors, compares gold vs gate outputs per vector, and reports pass/fail, mismatch count and first failing vector.
- Sits on the bench/FPGA side of the equivalence flow as the simulation counterpart of the formal miter's compare properties.

Parameters:
- PI_WIDTH, 2, total primary-input bits, concatenated in port order.
- PO_WIDTH, 2, total primary-output bits per side.
- LATENCY, 0, cycles from pi change to valid po on both sides; 0 means combinational.
- CNT_W, 16, width of vector counters and mismatch counter; PI_WIDTH <= CNT_W required.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle pulse that begins a run.
- mode  in  1  0 = exhaustive, 1 = LFSR.
- num_vectors  in  CNT_W  vector count in LFSR mode; sampled on start.
- pi  out  PI_WIDTH  registered stimulus to both gold and gate.
- pi_valid  out  1  pi carries a live vector.
- po_gold  in  PO_WIDTH  gold outputs.
- po_gate  in  PO_WIDTH  gate outputs.
- busy  out  1  run in progress.
- done  out  1  run finished; held until next start or reset.
- pass  out  1  done and zero mismatches.
- mismatch_count  out  CNT_W  saturating count of failing vectors.
- first_fail_valid  out  1  at least one mismatch recorded.
- first_fail_vec  out  CNT_W  index of first failing vector.

Behaviour:
- Reset: all outputs 0, FSM IDLE, LFSR = SEED. Reset mid-run aborts immediately with no done pulse.
- FSM states: IDLE -> RUN on start; RUN -> DRAIN after last vector issued; DRAIN -> DONE after LATENCY+1 compares drain; DONE -> RUN on start. With LATENCY = 0, DRAIN lasts 0 cycles.
- start is ignored while busy.
- start from IDLE or DONE clears done, pass, mismatch_count and first_fail_*, and latches mode and num_vectors.
- Vector count N:
  - Exhaustive: N = 2^PI_WIDTH, and num_vectors is ignored.
  - LFSR: N = num_vectors.
  - N = 0 goes straight to DONE one edge after start, with pass = 1.
- Issue timing: start sampled at edge 0. Vector k is on pi, with pi_valid = 1, during cycle k+1, for k = 0..N-1.
- pi value: exhaustive uses pi = k. LFSR uses the low PI_WIDTH bits of the LFSR, zero-extended when PI_WIDTH > 16; the LFSR advances once per issued vector.
- pi holds its last value and pi_valid = 0 outside RUN.
- Compare pipeline: valid and index shift register of depth LATENCY. Vector k is compared at edge k+1+LATENCY.
- Mismatch when po_gold != po_gate.
  - mismatch_count increments and saturates at 2^CNT_W-1.
  - first_fail_vec and first_fail_valid are captured only on the first mismatch.
- done, pass and the final count become visible after edge N+LATENCY. busy = 1 from edge 0 until that edge.
- pass = done && mismatch_count == 0.

Optional Feature:
- Macro: MITER_VECTOR_DRIVER_XCHECK_EN.
- When defined (simulation only), the per-bit compare is okay = (gold === 1'bx) || (gold === gate). X gold bits are don't-care; an X gate bit against a defined gold bit is a mismatch.
- A separate sticky output-x flag is not added. An X on any po_gold bit while comparing also fires an immediate assert.
- Without the macro, the compare is plain != and no assertion logic is present.

Decomposition:
- Package miter_vector_driver_pkg holds:
  - FSM state enum (IDLE, RUN, DRAIN, DONE).
  - LFSR constants: 16-bit Galois, taps 16'hB400, SEED 16'hACE1.
  - MODE_EXHAUSTIVE = 0 and MODE_LFSR = 1.
- One sub-module, miter_vector_cmp: PO_WIDTH-bit compare with the XCHECK variant.
- The LFSR stays inline.

Test Plan:
- Exhaustive, gold = gate = half adder (carry = a&b, sum = a^b), LATENCY = 0:
  - pi walks 0,1,2,3 in cycles 1-4.
  - done = 1, pass = 1, mismatch_count = 0 after edge 4.
- Same, but gate carry = a|b:
  - mismatches on vectors 1 and 2, so mismatch_count = 2.
  - first_fail_valid = 1, first_fail_vec = 1, pass = 0.
- LATENCY = 2 with both sides registered twice, exhaustive PI_WIDTH = 2:
  - done after edge 6, pass = 1.
  - Bench checks no compare occurs at edges 1-2.
- LFSR mode, num_vectors = 0 -> done = 1 and pass = 1 one edge after start, with pi_valid never asserted.
- LFSR mode, num_vectors = 100, with start re-pulsed at cycle 10 -> the second start is ignored and done rises after edge 100.
- Reset asserted at cycle 3 of an exhaustive run:
  - all outputs 0 immediately.
  - a later start gives a clean full run with pass = 1.

Source files
------------

// File: rtl/miter_vector_driver_pkg.sv
// Shared types and constants for the miter vector driver: FSM states, LFSR setup, run modes.
package miter_vector_driver_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam logic [15:0] LFSR_TAPS = 16'hB400;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    localparam logic MODE_EXHAUSTIVE = 1'b0;
    localparam logic MODE_LFSR       = 1'b1;

    // 16-bit right-shifting Galois LFSR step
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        lfsr_next = s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    endfunction

endpackage

// File: rtl/miter_vector_cmp.sv
// Gold/gate output comparator. Define MITER_VECTOR_DRIVER_XCHECK_EN (simulation only)
// to treat X gold bits as don't-care with a 4-state compare.
module miter_vector_cmp #(
    parameter int PO_WIDTH = 2
) (
    input  logic [PO_WIDTH-1:0] gold_i,
    input  logic [PO_WIDTH-1:0] gate_i,
    output logic                mismatch_o
);

`ifdef MITER_VECTOR_DRIVER_XCHECK_EN
    always_comb begin
        mismatch_o = 1'b0;
        for (int i = 0; i < PO_WIDTH; i++) begin
            if (!((gold_i[i] === 1'bx) || (gold_i[i] === gate_i[i])))
                mismatch_o = 1'b1;
        end
    end
`else
    assign mismatch_o = (gold_i != gate_i);
`endif

endmodule

// File: rtl/miter_vector_driver.sv
// Stimulus driver and output checker for a gold/gate miter pair (exhaustive or LFSR vectors).
// Optional 4-state compare and X assertion with MITER_VECTOR_DRIVER_XCHECK_EN.
//   state | meaning
//   IDLE  | waiting for first start
//   RUN   | issuing vectors onto pi
//   DRAIN | last vector issued, waiting LATENCY compares
//   DONE  | results held until next start
module miter_vector_driver
    import miter_vector_driver_pkg::*;
#(
    parameter int PI_WIDTH = 2,
    parameter int PO_WIDTH = 2,
    parameter int LATENCY  = 0,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                mode,
    input  logic [CNT_W-1:0]    num_vectors,
    output logic [PI_WIDTH-1:0] pi,
    output logic                pi_valid,
    input  logic [PO_WIDTH-1:0] po_gold,
    input  logic [PO_WIDTH-1:0] po_gate,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [CNT_W-1:0]    mismatch_count,
    output logic                first_fail_valid,
    output logic [CNT_W-1:0]    first_fail_vec
);

    // One extra bit so an exhaustive run of 2^CNT_W vectors is representable
    localparam int NW   = CNT_W + 1;
    localparam int DW   = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam int EXTW = (PI_WIDTH > 16) ? PI_WIDTH : 16;
    localparam logic [DW-1:0] DRAIN_LOAD = DW'((LATENCY == 0) ? 0 : LATENCY - 1);

    state_t               state_q, state_d;
    logic                 mode_q, mode_d;
    logic [NW-1:0]        n_q, n_d;
    logic [NW-1:0]        idx_q, idx_d;
    logic [PI_WIDTH-1:0]  pi_q, pi_d;
    logic                 pi_valid_q, pi_valid_d;
    logic [CNT_W-1:0]     pi_idx_q, pi_idx_d;
    logic [15:0]          lfsr_q, lfsr_d;
    logic [DW-1:0]        drain_q, drain_d;
    logic [CNT_W-1:0]     mm_cnt_q, mm_cnt_d;
    logic                 ff_valid_q, ff_valid_d;
    logic [CNT_W-1:0]     ff_vec_q, ff_vec_d;

    logic                 cmp_valid;
    logic [CNT_W-1:0]     cmp_idx;
    logic                 mismatch;
    logic [NW-1:0]        n_start;
    logic                 issue;
    logic                 issue_mode;
    logic [NW-1:0]        issue_idx;
    logic [EXTW-1:0]      lfsr_ext;

    assign lfsr_ext = EXTW'(lfsr_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            mode_q     <= MODE_EXHAUSTIVE;
            n_q        <= '0;
            idx_q      <= '0;
            pi_q       <= '0;
            pi_valid_q <= 1'b0;
            pi_idx_q   <= '0;
            lfsr_q     <= LFSR_SEED;
            drain_q    <= '0;
            mm_cnt_q   <= '0;
            ff_valid_q <= 1'b0;
            ff_vec_q   <= '0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            n_q        <= n_d;
            idx_q      <= idx_d;
            pi_q       <= pi_d;
            pi_valid_q <= pi_valid_d;
            pi_idx_q   <= pi_idx_d;
            lfsr_q     <= lfsr_d;
            drain_q    <= drain_d;
            mm_cnt_q   <= mm_cnt_d;
            ff_valid_q <= ff_valid_d;
            ff_vec_q   <= ff_vec_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        n_d        = n_q;
        idx_d      = idx_q;
        pi_d       = pi_q;
        pi_valid_d = pi_valid_q;
        pi_idx_d   = pi_idx_q;
        lfsr_d     = lfsr_q;
        drain_d    = drain_q;
        mm_cnt_d   = mm_cnt_q;
        ff_valid_d = ff_valid_q;
        ff_vec_d   = ff_vec_q;
        issue      = 1'b0;
        issue_mode = mode_q;
        issue_idx  = idx_q;
        n_start    = (mode == MODE_LFSR) ? {1'b0, num_vectors} : (NW'(1) << PI_WIDTH);

        if (cmp_valid && mismatch) begin
            if (mm_cnt_q != '1)
                mm_cnt_d = mm_cnt_q + 1'b1;
            if (!ff_valid_q) begin
                ff_valid_d = 1'b1;
                ff_vec_d   = cmp_idx;
            end
        end

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d    = RUN;
                    mode_d     = mode;
                    n_d        = n_start;
                    mm_cnt_d   = '0;
                    ff_valid_d = 1'b0;
                    ff_vec_d   = '0;
                    issue      = (n_start != '0);
                    issue_mode = mode;
                    issue_idx  = '0;
                end
            end
            RUN: begin
                if (idx_q < n_q) begin
                    issue = 1'b1;
                end else begin
                    pi_valid_d = 1'b0;
                    drain_d    = DRAIN_LOAD;
                    state_d    = (n_q == '0 || LATENCY == 0) ? DONE : DRAIN;
                end
            end
            DRAIN: begin
                if (drain_q == '0)
                    state_d = DONE;
                else
                    drain_d = drain_q - 1'b1;
            end
            default: state_d = IDLE;
        endcase

        if (issue) begin
            pi_d       = (issue_mode == MODE_LFSR) ? lfsr_ext[PI_WIDTH-1:0] : issue_idx[PI_WIDTH-1:0];
            pi_valid_d = 1'b1;
            pi_idx_d   = issue_idx[CNT_W-1:0];
            idx_d      = issue_idx + 1'b1;
            if (issue_mode == MODE_LFSR)
                lfsr_d = lfsr_next(lfsr_q);
        end
    end

    // Compare-side delay line matching the DUT-pair latency
    generate
        if (LATENCY == 0) begin : g_comb
            assign cmp_valid = pi_valid_q;
            assign cmp_idx   = pi_idx_q;
        end else begin : g_pipe
            logic             vld_q [LATENCY];
            logic [CNT_W-1:0] idp_q [LATENCY];
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    for (int i = 0; i < LATENCY; i++) begin
                        vld_q[i] <= 1'b0;
                        idp_q[i] <= '0;
                    end
                end else begin
                    vld_q[0] <= pi_valid_q;
                    idp_q[0] <= pi_idx_q;
                    for (int i = 1; i < LATENCY; i++) begin
                        vld_q[i] <= vld_q[i-1];
                        idp_q[i] <= idp_q[i-1];
                    end
                end
            end
            assign cmp_valid = vld_q[LATENCY-1];
            assign cmp_idx   = idp_q[LATENCY-1];
        end
    endgenerate

    miter_vector_cmp #(.PO_WIDTH(PO_WIDTH)) u_cmp (
        .gold_i     (po_gold),
        .gate_i     (po_gate),
        .mismatch_o (mismatch)
    );

`ifdef MITER_VECTOR_DRIVER_XCHECK_EN
    always_ff @(posedge clk) begin
        if (!reset && cmp_valid)
            assert (!$isunknown(po_gold)) else $error("po_gold carries X during compare");
    end
`endif

    assign pi               = pi_q;
    assign pi_valid         = pi_valid_q;
    assign busy             = (state_q == RUN) || (state_q == DRAIN);
    assign done             = (state_q == DONE);
    assign pass             = done && (mm_cnt_q == '0);
    assign mismatch_count   = mm_cnt_q;
    assign first_fail_valid = ff_valid_q;
    assign first_fail_vec   = ff_vec_q;

endmodule

// File: tb/tb_miter_vector_driver.sv
// Directed bench: half-adder gold/gate pair on a LATENCY=0 and a LATENCY=2 driver instance.
module tb_miter_vector_driver;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // LATENCY = 0 instance
    logic        start0 = 0, mode0 = 0, bug0 = 0;
    logic [15:0] nv0 = '0;
    logic [1:0]  pi0, gold0, gate0;
    logic        pv0, busy0, done0, pass0, ffv0;
    logic [15:0] cnt0, ffvec0;

    // LATENCY = 2 instance
    logic        start2 = 0, mode2 = 0, bug2 = 0;
    logic [15:0] nv2 = '0;
    logic [1:0]  pi2, g1 = '0, g2 = '0, t1 = '0, t2 = '0;
    logic        pv2, busy2, done2, pass2, ffv2;
    logic [15:0] cnt2, ffvec2;

    function automatic logic [1:0] ha(input logic [1:0] p);
        return {p[1] & p[0], p[1] ^ p[0]};
    endfunction
    function automatic logic [1:0] ha_bad(input logic [1:0] p);
        return {p[1] | p[0], p[1] ^ p[0]};
    endfunction

    assign gold0 = ha(pi0);
    assign gate0 = bug0 ? ha_bad(pi0) : ha(pi0);

    always @(posedge clk) begin
        g1 <= ha(pi2);
        g2 <= g1;
        t1 <= bug2 ? ha_bad(pi2) : ha(pi2);
        t2 <= t1;
    end

    miter_vector_driver #(.PI_WIDTH(2), .PO_WIDTH(2), .LATENCY(0), .CNT_W(16)) u0 (
        .clk(clk), .reset(reset), .start(start0), .mode(mode0), .num_vectors(nv0),
        .pi(pi0), .pi_valid(pv0), .po_gold(gold0), .po_gate(gate0),
        .busy(busy0), .done(done0), .pass(pass0), .mismatch_count(cnt0),
        .first_fail_valid(ffv0), .first_fail_vec(ffvec0)
    );

    miter_vector_driver #(.PI_WIDTH(2), .PO_WIDTH(2), .LATENCY(2), .CNT_W(16)) u2 (
        .clk(clk), .reset(reset), .start(start2), .mode(mode2), .num_vectors(nv2),
        .pi(pi2), .pi_valid(pv2), .po_gold(g2), .po_gate(t2),
        .busy(busy2), .done(done2), .pass(pass2), .mismatch_count(cnt2),
        .first_fail_valid(ffv2), .first_fail_vec(ffvec2)
    );

    task automatic do_reset();
        @(negedge clk) reset = 1'b1;
        @(negedge clk) reset = 1'b0;
    endtask

    // Leaves the bench sampling just after edge 0 of the run on instance 0
    task automatic start_u0(input logic m, input logic [15:0] n);
        @(negedge clk);
        start0 = 1'b1; mode0 = m; nv0 = n;
        @(negedge clk);
        start0 = 1'b0;
    endtask

    task automatic start_u2();
        @(negedge clk);
        start2 = 1'b1; mode2 = 1'b0;
        @(negedge clk);
        start2 = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({pi0, pv0, busy0, done0, pass0, cnt0, ffv0, ffvec0} !== 38'd0) begin
            errors++;
            $display("FAIL reset_u0: got %h want 0", {pi0, pv0, busy0, done0, pass0, cnt0, ffv0, ffvec0});
        end
        checks++;
        if ({pi2, pv2, busy2, done2, pass2, cnt2, ffv2, ffvec2} !== 38'd0) begin
            errors++;
            $display("FAIL reset_u2: got %h want 0", {pi2, pv2, busy2, done2, pass2, cnt2, ffv2, ffvec2});
        end
    endtask

    task automatic test_exhaustive_pass();
        bug0 = 1'b0;
        start_u0(1'b0, 16'd7);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if ({pi0, pv0, busy0, done0} !== {k[1:0], 3'b110}) begin
                errors++;
                $display("FAIL exh_issue k=%0d: got pi=%0d pv=%b busy=%b done=%b want pi=%0d pv=1 busy=1 done=0",
                         k, pi0, pv0, busy0, done0, k);
            end
            @(negedge clk);
        end
        checks++;
        if ({done0, pass0, busy0, pv0, cnt0} !== {4'b1100, 16'd0}) begin
            errors++;
            $display("FAIL exh_pass_end: got done=%b pass=%b busy=%b pv=%b cnt=%0d want 1 1 0 0 0",
                     done0, pass0, busy0, pv0, cnt0);
        end
    endtask

    task automatic test_exhaustive_fail();
        bug0 = 1'b1;
        start_u0(1'b0, 16'd0);
        @(negedge clk);
        checks++;
        if (cnt0 !== 16'd0) begin
            errors++; $display("FAIL exh_fail_e1: got cnt=%0d want 0", cnt0);
        end
        @(negedge clk);
        checks++;
        if ({cnt0, ffv0, ffvec0} !== {16'd1, 1'b1, 16'd1}) begin
            errors++; $display("FAIL exh_fail_e2: got cnt=%0d ffv=%b ffvec=%0d want 1 1 1", cnt0, ffv0, ffvec0);
        end
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({done0, pass0, cnt0, ffv0, ffvec0} !== {2'b10, 16'd2, 1'b1, 16'd1}) begin
            errors++;
            $display("FAIL exh_fail_end: got done=%b pass=%b cnt=%0d ffv=%b ffvec=%0d want 1 0 2 1 1",
                     done0, pass0, cnt0, ffv0, ffvec0);
        end
        bug0 = 1'b0;
    endtask

    task automatic test_latency2();
        logic [15:0] exp_cnt [7] = '{16'd0, 16'd0, 16'd0, 16'd0, 16'd1, 16'd2, 16'd2};
        bug2 = 1'b1;
        start_u2();
        for (int e = 1; e <= 6; e++) begin
            @(negedge clk);
            checks++;
            if (cnt2 !== exp_cnt[e]) begin
                errors++; $display("FAIL lat2_cnt e=%0d: got %0d want %0d", e, cnt2, exp_cnt[e]);
            end
        end
        checks++;
        if ({done2, pass2, ffv2, ffvec2} !== {3'b101, 16'd1}) begin
            errors++; $display("FAIL lat2_fail_end: got done=%b pass=%b ffv=%b ffvec=%0d want 1 0 1 1",
                               done2, pass2, ffv2, ffvec2);
        end
        bug2 = 1'b0;
        start_u2();
        checks++;
        if ({done2, busy2, cnt2, ffv2} !== {2'b01, 16'd0, 1'b0}) begin
            errors++; $display("FAIL lat2_restart_clear: got done=%b busy=%b cnt=%0d ffv=%b want 0 1 0 0",
                               done2, busy2, cnt2, ffv2);
        end
        repeat (5) @(negedge clk);
        checks++;
        if ({done2, busy2} !== 2'b01) begin
            errors++; $display("FAIL lat2_e5: got done=%b busy=%b want 0 1", done2, busy2);
        end
        @(negedge clk);
        checks++;
        if ({done2, pass2, busy2, cnt2} !== {3'b110, 16'd0}) begin
            errors++; $display("FAIL lat2_pass_end: got done=%b pass=%b busy=%b cnt=%0d want 1 1 0 0",
                               done2, pass2, busy2, cnt2);
        end
    endtask

    task automatic test_lfsr_zero();
        logic saw_pv;
        do_reset();
        start_u0(1'b1, 16'd0);
        saw_pv = pv0;
        @(negedge clk);
        saw_pv = saw_pv | pv0;
        checks++;
        if ({done0, pass0, busy0, saw_pv} !== 4'b1100) begin
            errors++; $display("FAIL lfsr_zero: got done=%b pass=%b busy=%b pv_seen=%b want 1 1 0 0",
                               done0, pass0, busy0, saw_pv);
        end
    endtask

    task automatic test_lfsr_restart();
        int pv_cycles;
        do_reset();
        start_u0(1'b1, 16'd100);
        pv_cycles = 0;
        for (int e = 0; e <= 100; e++) begin
            if (pv0) pv_cycles++;
            if (e == 0) begin
                checks++;
                if (pi0 !== 2'd1) begin errors++; $display("FAIL lfsr_pi e0: got %0d want 1", pi0); end
            end
            if (e == 4) begin
                checks++;
                if (pi0 !== 2'd2) begin errors++; $display("FAIL lfsr_pi e4: got %0d want 2", pi0); end
            end
            if (e == 99) begin
                checks++;
                if ({done0, busy0} !== 2'b01) begin
                    errors++; $display("FAIL lfsr_e99: got done=%b busy=%b want 0 1", done0, busy0);
                end
            end
            // cycle 10: re-pulse start with different settings; must be ignored
            start0 = (e == 9);
            mode0  = (e == 9) ? 1'b0 : 1'b1;
            nv0    = (e == 9) ? 16'd5 : 16'd100;
            if (e < 100) @(negedge clk);
        end
        checks++;
        if ({done0, pass0, busy0, cnt0} !== {3'b110, 16'd0}) begin
            errors++; $display("FAIL lfsr_end: got done=%b pass=%b busy=%b cnt=%0d want 1 1 0 0",
                               done0, pass0, busy0, cnt0);
        end
        checks++;
        if (pv_cycles !== 100) begin
            errors++; $display("FAIL lfsr_pv_cycles: got %0d want 100", pv_cycles);
        end
    endtask

    task automatic test_reset_midrun();
        logic saw_done;
        do_reset();
        bug0 = 1'b1;
        start_u0(1'b0, 16'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if ({pi0, pv0, busy0, done0, pass0, cnt0, ffv0, ffvec0} !== 38'd0) begin
            errors++;
            $display("FAIL midrun_reset: got %h want 0", {pi0, pv0, busy0, done0, pass0, cnt0, ffv0, ffvec0});
        end
        @(negedge clk) reset = 1'b0;
        bug0 = 1'b0;
        saw_done = 1'b0;
        repeat (6) begin
            @(negedge clk);
            saw_done = saw_done | done0;
        end
        checks++;
        if (saw_done !== 1'b0) begin
            errors++; $display("FAIL midrun_no_done: got done seen=%b want 0", saw_done);
        end
        start_u0(1'b0, 16'd0);
        repeat (3) @(negedge clk);
        checks++;
        if (done0 !== 1'b0) begin errors++; $display("FAIL midrun_rerun_e3: got done=%b want 0", done0); end
        @(negedge clk);
        checks++;
        if ({done0, pass0, cnt0} !== {2'b11, 16'd0}) begin
            errors++; $display("FAIL midrun_rerun_end: got done=%b pass=%b cnt=%0d want 1 1 0", done0, pass0, cnt0);
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        test_reset();
        test_exhaustive_pass();
        test_exhaustive_fail();
        test_latency2();
        test_lfsr_zero();
        test_lfsr_restart();
        test_reset_midrun();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
